stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Control sequencer for the 10 Hz stopwatch timer. Takes the two raw DE10 push-buttons (start/stop and lap/reset), synchronises and debounces them, and runs the stopwatch state machine. Drives the timer's enable and synchronous active-high reset. Muxes the live or frozen lap time (tenth_sec/sec) onto the display path feeding the 7-segment decoders.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, stable-level cycles needed to accept a key change (20 ms at 50 MHz)
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
KEY_ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed (DE10 KEYs); 0 = active-high key

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  one clock; reset is synchronous and active-low
key_ss  in  1  raw asynchronous start/stop button
key_lr  in  1  raw asynchronous lap/reset button
tenth_sec  in  4  live tenth count from timer, 0-9
sec  in  6  live second count from timer, 0-59
timer_en  out  1  enable to timer
timer_reset  out  1  synchronous active-high reset to timer
disp_tenth  out  4  tenth value for display
disp_sec  out  6  second value for display
running  out  1  1 in RUN or LAP
lap_active  out  1  1 in LAP (display frozen)

Behaviour:
- Reset (reset_n=0 at a clk edge): state=CLEAR, timer_en=0, timer_reset=1, disp_tenth=0, disp_sec=0, lap registers=0, running=0, lap_active=0. Sync flops, debounce counters and stable levels go to "released".
- Key path, identical per key: 2-flop synchroniser -> debounce -> press pulse.
  - Counter clears while the synced level equals the stable level.
  - Counter increments while the levels differ. At DEBOUNCE_CYCLES consecutive differing cycles, the stable level takes the synced level and the counter clears.
  - Press pulse (ss_p, lr_p) is exactly one cycle, on the stable transition released->pressed. No pulse on release. Holding a key gives a single pulse.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- FSM states: CLEAR, IDLE, RUN, LAP, PAUSE. State and all outputs are registered; each reacts on the edge after the pulse.
  - CLEAR: timer_reset=1, timer_en=0; unconditionally -> IDLE next cycle. timer_reset is asserted for exactly one cycle after leaving reset or after a reset command.
  - IDLE: ss_p -> RUN. lr_p ignored.
  - RUN: timer_en=1. ss_p -> PAUSE. lr_p -> LAP, and lap registers capture tenth_sec/sec on that same edge.
  - LAP: timer_en=1, display frozen. lr_p -> RUN (display live). ss_p -> PAUSE (freeze released).
  - PAUSE: timer_en=0. ss_p -> RUN. lr_p -> CLEAR (timer zeroed, then IDLE).
- Simultaneous ss_p and lr_p in the same cycle: ss_p wins; lr_p is dropped.
- Display: disp_* is registered, one-cycle latency from the inputs.
  - In LAP: disp_* = lap registers.
  - In all other states: disp_* = tenth_sec/sec.
  - CLEAR forces disp_*=0.
- running=1 in RUN/LAP. lap_active=1 in LAP only. timer_reset=0 in every state except CLEAR.
- Reset mid-operation (any state, including mid-debounce): full reset values apply next edge; in-flight presses are discarded.
- Latency, key held pressed from edge 0: pulse at edge 2+DEBOUNCE_CYCLES (±1); timer_en changes one edge later.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
1. Hold reset_n=0 for 3 cycles, then release -> during reset timer_reset=1, timer_en=0, disp=0; first cycle after release timer_reset=1 (CLEAR); next cycle 0, state IDLE.
2. Hold key_ss=0 for 10 cycles -> one ss_p, timer_en rises about 7 edges after the press and stays 1 after key release; running=1. Second press -> timer_en=0.
3. Glitch key_lr low for 3 cycles in RUN -> no state change, lap_active stays 0. Hold 6 cycles with tenth_sec=7, sec=12 -> lap_active=1, disp_tenth=7, disp_sec=12 held while inputs advance to 9/15; second lr press -> disp tracks live.
4. In PAUSE, press key_lr -> exactly one cycle of timer_reset=1, then IDLE, disp=0. Press key_lr again in IDLE -> no effect.
5. Force ss_p and lr_p in the same cycle in RUN (both keys pressed together) -> PAUSE, no lap capture. Assert reset_n=0 mid-debounce of key_ss -> after reset, no spurious pulse.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: two debounced push-buttons drive a five-state
// controller that enables/clears the 10 Hz timer and selects live or lap time for display.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_ss,
  input  logic       key_lr,
  input  logic [3:0] tenth_sec,
  input  logic [5:0] sec,
  output logic       timer_en,
  output logic       timer_reset,
  output logic [3:0] disp_tenth,
  output logic [5:0] disp_sec,
  output logic       running,
  output logic       lap_active
);

  localparam logic RELEASED = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_RUN,
    ST_LAP,
    ST_PAUSE
  } state_t;

  logic [1:0] key_raw;
  logic [1:0] press_pulse;
  logic       ss_p;
  logic       lr_p;

  assign key_raw = {key_lr, key_ss};
  assign ss_p    = press_pulse[0];
  assign lr_p    = press_pulse[1];

  // Per key: 2-flop synchroniser, stable-level debounce, one-cycle press pulse.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      logic             sync1_reg;
      logic             sync2_reg;
      logic             stable_reg;
      logic             pulse_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          sync1_reg  <= RELEASED;
          sync2_reg  <= RELEASED;
          stable_reg <= RELEASED;
          pulse_reg  <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          sync1_reg <= key_raw[gi];
          sync2_reg <= sync1_reg;
          pulse_reg <= 1'b0;
          if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
            pulse_reg  <= (sync2_reg != RELEASED);
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      assign press_pulse[gi] = pulse_reg;
    end
  endgenerate

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] lap_tenth_reg;
  logic [3:0] lap_tenth_next;
  logic [5:0] lap_sec_reg;
  logic [5:0] lap_sec_next;
  logic       timer_en_reg;
  logic       timer_en_next;
  logic       timer_reset_reg;
  logic       timer_reset_next;
  logic [3:0] disp_tenth_reg;
  logic [3:0] disp_tenth_next;
  logic [5:0] disp_sec_reg;
  logic [5:0] disp_sec_next;
  logic       running_reg;
  logic       running_next;
  logic       lap_active_reg;
  logic       lap_active_next;

  // Start/stop is checked first everywhere, so a simultaneous lap/reset press is dropped.
  always_comb begin
    state_next     = state_reg;
    lap_tenth_next = lap_tenth_reg;
    lap_sec_next   = lap_sec_reg;
    case (state_reg)
      ST_CLEAR: state_next = ST_IDLE;
      ST_IDLE: begin
        if (ss_p) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (ss_p) begin
          state_next = ST_PAUSE;
        end else if (lr_p) begin
          state_next     = ST_LAP;
          lap_tenth_next = tenth_sec;
          lap_sec_next   = sec;
        end
      end
      ST_LAP: begin
        if (ss_p) state_next = ST_PAUSE;
        else if (lr_p) state_next = ST_RUN;
      end
      ST_PAUSE: begin
        if (ss_p) state_next = ST_RUN;
        else if (lr_p) state_next = ST_CLEAR;
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  // Outputs are decoded from the state being entered so they register alongside it.
  always_comb begin
    timer_en_next    = (state_next == ST_RUN) || (state_next == ST_LAP);
    running_next     = (state_next == ST_RUN) || (state_next == ST_LAP);
    lap_active_next  = (state_next == ST_LAP);
    timer_reset_next = (state_next == ST_CLEAR);
    disp_tenth_next  = tenth_sec;
    disp_sec_next    = sec;
    if (state_next == ST_CLEAR) begin
      disp_tenth_next = '0;
      disp_sec_next   = '0;
    end else if (state_next == ST_LAP) begin
      disp_tenth_next = lap_tenth_next;
      disp_sec_next   = lap_sec_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= ST_CLEAR;
      lap_tenth_reg   <= '0;
      lap_sec_reg     <= '0;
      timer_en_reg    <= 1'b0;
      timer_reset_reg <= 1'b1;
      disp_tenth_reg  <= '0;
      disp_sec_reg    <= '0;
      running_reg     <= 1'b0;
      lap_active_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      lap_tenth_reg   <= lap_tenth_next;
      lap_sec_reg     <= lap_sec_next;
      timer_en_reg    <= timer_en_next;
      timer_reset_reg <= timer_reset_next;
      disp_tenth_reg  <= disp_tenth_next;
      disp_sec_reg    <= disp_sec_next;
      running_reg     <= running_next;
      lap_active_reg  <= lap_active_next;
    end
  end

  assign timer_en    = timer_en_reg;
  assign timer_reset = timer_reset_reg;
  assign disp_tenth  = disp_tenth_reg;
  assign disp_sec    = disp_sec_reg;
  assign running     = running_reg;
  assign lap_active  = lap_active_reg;

endmodule
